// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder controller.
package bcd_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned BCD_MAX  = 9;
  localparam int unsigned BCD_CORR = 6;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/bcd_serial_adder_ctrl_if.sv
// Host-side start/done handshake and operand/result bus of the serial BCD adder.
interface bcd_serial_adder_ctrl_if #(
    parameter int unsigned DIGITS = 4
) ();
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   s;
    logic                  cout;
    logic                  err;

    modport master (
        output start, a, b, cin,
        input  ready, busy, done, s, cout, err
    );

    modport slave (
        input  start, a, b, cin,
        output ready, busy, done, s, cout, err
    );
endinterface

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder; invalid input digits still give a defined result.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               ci,
    output logic [DIGIT_W-1:0] d,
    output logic               co,
    output logic               bad
);
    logic [DIGIT_W:0] t;

    always_comb begin
        t   = {1'b0, x} + {1'b0, y} + {{DIGIT_W{1'b0}}, ci};
        d   = t[DIGIT_W-1:0];
        co  = 1'b0;
        if (t > (DIGIT_W+1)'(BCD_MAX)) begin
            // Decimal correction wraps mod 16, dropping the binary carry.
            d  = t[DIGIT_W-1:0] + DIGIT_W'(BCD_CORR);
            co = 1'b1;
        end
        bad = (x > DIGIT_W'(BCD_MAX)) | (y > DIGIT_W'(BCD_MAX));
    end
endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit BCD adder: one shared digit stage, LSD first, one digit per clock.
module bcd_serial_adder_ctrl
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    bcd_serial_adder_ctrl_if.slave  bus
);
    localparam int unsigned IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned W    = DIGIT_W * DIGITS;

    state_e            state_q;
    logic [W-1:0]      a_q, b_q, s_q;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q, cout_q, err_q;
    logic              ready_q, busy_q, done_q;

    logic [DIGIT_W-1:0] dig_x, dig_y, dig_d;
    logic               dig_co, dig_bad;

    assign dig_x = a_q[idx_q*DIGIT_W +: DIGIT_W];
    assign dig_y = b_q[idx_q*DIGIT_W +: DIGIT_W];

    bcd_digit_add u_digit (
        .x   (dig_x),
        .y   (dig_y),
        .ci  (carry_q),
        .d   (dig_d),
        .co  (dig_co),
        .bad (dig_bad)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        idx_q   <= '0;
                        s_q     <= '0;
                        cout_q  <= 1'b0;
                        err_q   <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    s_q[idx_q*DIGIT_W +: DIGIT_W] <= dig_d;
                    carry_q <= dig_co;
                    idx_q   <= idx_q + 1'b1;
                    err_q   <= err_q | dig_bad;
                    if (idx_q == IDXW'(DIGITS - 1)) begin
                        cout_q  <= dig_co;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.s     = s_q;
    assign bus.cout  = cout_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed self-checking bench for the serial BCD adder controller.
module tb_bcd_serial_adder_ctrl;
    import bcd_pkg::*;

    localparam int unsigned DIGITS = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bcd_serial_adder_ctrl_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        cout;
        logic        err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Returns at the negedge where done is seen; lat counts edges after acceptance.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                          output int lat);
        @(negedge clk);
        bus.a     = ta;
        bus.b     = tb_v;
        bus.cin   = tc;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~ta;
        bus.b     = ~tb_v;
        bus.cin   = ~tc;
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int dones;

        vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
        vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0999, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
        vecs[3] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
        vecs[4] = '{16'h000A, 16'h0001, 1'b0, 16'h0011, 1'b0, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[6] = '{16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0};
        vecs[7] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_busy",  32'(bus.busy),  32'd0);
        chk("rst_done",  32'(bus.done),  32'd0);
        chk("rst_s",     32'(bus.s),     32'd0);
        chk("rst_cout",  32'(bus.cout),  32'd0);
        chk("rst_err",   32'(bus.err),   32'd0);

        // start together with rst must not be accepted
        bus.start = 1'b1;
        bus.a     = 16'h1111;
        @(negedge clk);
        chk("rst_start_busy",  32'(bus.busy),  32'd0);
        chk("rst_start_ready", 32'(bus.ready), 32'd1);
        bus.start = 1'b0;
        rst       = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(DIGITS));
            chk($sformatf("v%0d_s", i),    32'(bus.s),    32'(vecs[i].s));
            chk($sformatf("v%0d_cout", i), 32'(bus.cout), 32'(vecs[i].cout));
            chk($sformatf("v%0d_err", i),  32'(bus.err),  32'(vecs[i].err));
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 32'(bus.done),  32'd0);
            chk($sformatf("v%0d_ready_back", i), 32'(bus.ready), 32'd1);
            chk($sformatf("v%0d_s_held", i),     32'(bus.s),     32'(vecs[i].s));
        end

        // start while busy is ignored, not queued
        bus.a = 16'h1234; bus.b = 16'h5678; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        for (int c = 0; c < 16; c++) begin
            if (c == 2) begin
                bus.a = 16'h2222; bus.b = 16'h3333; bus.cin = 1'b1; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("busy_start_dones", 32'(dones), 32'd1);
        chk("busy_start_s",     32'(bus.s), 32'h6912);
        chk("busy_start_busy",  32'(bus.busy), 32'd0);

        // reset in the middle of RUN
        @(negedge clk);
        bus.a = 16'h9999; bus.b = 16'h0001; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", 32'(bus.ready), 32'd1);
        chk("mid_rst_busy",  32'(bus.busy),  32'd0);
        chk("mid_rst_s",     32'(bus.s),     32'd0);
        chk("mid_rst_cout",  32'(bus.cout),  32'd0);
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        chk("mid_rst_no_done", 32'(dones), 32'd0);
        run_op(16'h0458, 16'h0027, 1'b0, lat);
        chk("after_rst_latency", 32'(lat),     32'(DIGITS));
        chk("after_rst_s",       32'(bus.s),   32'h0485);
        chk("after_rst_cout",    32'(bus.cout), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
